// File: rtl/dmux_sel_sequencer_if.sv
// Purpose: command and output bundle between a controller and dmux_sel_sequencer.
// Latency: none; this is only wiring.
// Backpressure: none; commands are level-sampled and outputs are always valid.
// Ports: start, stop, mask[3:0], din are driven by master; s[1:0], i, busy, wrap are driven by slave.
interface dmux_sel_sequencer_if;
  logic       start;
  logic       stop;
  logic [3:0] mask;
  logic       din;
  logic [1:0] s;
  logic       i;
  logic       busy;
  logic       wrap;

  modport master (
    output start, stop, mask, din,
    input  s, i, busy, wrap
  );

  modport slave (
    input  start, stop, mask, din,
    output s, i, busy, wrap
  );
endinterface

// File: rtl/dmux_sel_sequencer.sv
// Purpose: round-robin select/data driver for a 1-to-4 demux; each enabled channel is held DWELL cycles.
// Latency: din reaches i one cycle later; s, i, busy and wrap all come straight from flops.
// Backpressure: none; stop or an all-zero mask ends sequencing at the next dwell boundary.
// Ports: clk, rst (async, active-high); sq (slave): start, stop, mask, din in; s, i, busy, wrap out.
module dmux_sel_sequencer #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  dmux_sel_sequencer_if.slave sq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      s_q, s_d;
  logic            i_q, i_d;
  logic            busy_q, busy_d;
  logic            wrap_q, wrap_d;

  logic [1:0]      nxt_ch;
  logic [1:0]      low_ch;
  logic            dwell_end;
  logic            drain_req;

  // First enabled channel above cur, wrapping 3->0, with cur itself tried last.
  // Scanning from the farthest candidate down lets the nearest one overwrite.
  function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] c;
    next_ch = cur;
    for (int k = 4; k >= 1; k--) begin
      c = cur + 2'(k);
      if (m[c]) next_ch = c;
    end
  endfunction

  assign nxt_ch    = next_ch(s_q, sq.mask);
  // Scanning upward from channel 3 starts at 0, so this is the lowest set bit.
  assign low_ch    = next_ch(2'd3, sq.mask);
  assign dwell_end = (cnt_q == LAST);
  // In RUN, stop requests a drain; in DRAIN, only start without stop cancels it.
  assign drain_req = (state_q == DRAIN) ? (sq.stop || !sq.start) : sq.stop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    i_d     = 1'b0;
    busy_d  = busy_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sq.start && (sq.mask != 4'b0000)) begin
          state_d = RUN;
          s_d     = low_ch;
          cnt_d   = '0;
          i_d     = sq.din;
          busy_d  = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (dwell_end) begin
          cnt_d = '0;
          if (drain_req || (sq.mask == 4'b0000)) begin
            // Leave s on the channel just finished; no wrap on the way out.
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = RUN;
            s_d     = nxt_ch;
            wrap_d  = (nxt_ch <= s_q);
            i_d     = sq.din;
          end
        end else begin
          state_d = drain_req ? DRAIN : RUN;
          cnt_d   = cnt_q + 1'b1;
          i_d     = sq.din;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= 2'b00;
      i_q     <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      i_q     <= i_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  assign sq.s    = s_q;
  assign sq.i    = i_q;
  assign sq.busy = busy_q;
  assign sq.wrap = wrap_q;

endmodule
